// File: rtl/code_step_if.sv
// Sample stream in, per-comparison step-relation flags and event counters out.
// The slave side is the monitor; the master side is whatever feeds samples and reads results.
interface code_step_if #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             gray;
  logic             dist_match;
  logic             more;
  logic             less;
  logic             no_relation;
  logic             run_ok;
  logic [CNT_W-1:0] cnt_gray;
  logic [CNT_W-1:0] cnt_none;
  logic             state_dbg;

  modport master (
    output in_valid, in_data,
    input  out_valid, gray, dist_match, more, less, no_relation, run_ok,
    input  cnt_gray, cnt_none, state_dbg
  );

  modport slave (
    input  in_valid, in_data,
    output out_valid, gray, dist_match, more, less, no_relation, run_ok,
    output cnt_gray, cnt_none, state_dbg
  );
endinterface

// File: rtl/code_step_monitor.sv
// Compares each accepted sample with the previous one and reports gray/distance/+1/-1
// relations, a gray-run indicator and saturating event counters, all registered.
module code_step_monitor #(
  parameter int WIDTH   = 3,
  parameter int DIST    = 3,
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  code_step_if.slave bus
);
  // Handshake: in_valid=1 means in_data is consumed on this rising edge (no backpressure);
  // out_valid is a single-cycle pulse marking the flags as describing a fresh comparison.

  localparam int RUN_W = $clog2(RUN_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);
  localparam logic [WIDTH:0]   DIST_X  = (WIDTH+1)'(DIST);

  typedef enum logic {EMPTY = 1'b0, TRACK = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             out_valid_q, out_valid_d;
  logic             gray_q, gray_d;
  logic             dist_q, dist_d;
  logic             more_q, more_d;
  logic             less_q, less_d;
  logic             none_q, none_d;
  logic             run_ok_q, run_ok_d;
  logic [CNT_W-1:0] cnt_gray_q, cnt_gray_d;
  logic [CNT_W-1:0] cnt_none_q, cnt_none_d;

  // Zero-extended operands so that wrap-around steps (e.g. max -> 0) are not adjacent.
  logic [WIDTH:0]   cur_x, prev_x, abs_diff;
  logic             gray_c, dist_c, more_c, less_c, none_c;
  logic [RUN_W-1:0] run_next;

  always_comb begin
    cur_x    = {1'b0, bus.in_data};
    prev_x   = {1'b0, prev_q};
    abs_diff = (cur_x >= prev_x) ? (cur_x - prev_x) : (prev_x - cur_x);
    gray_c   = ($countones(bus.in_data ^ prev_q) == 1);
    dist_c   = (abs_diff == DIST_X);
    more_c   = (cur_x == prev_x + (WIDTH+1)'(1));
    less_c   = (prev_x == cur_x + (WIDTH+1)'(1));
    none_c   = !(gray_c || dist_c || more_c || less_c);
    run_next = gray_c ? ((run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1)) : '0;
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    run_d       = run_q;
    out_valid_d = 1'b0;
    gray_d      = gray_q;
    dist_d      = dist_q;
    more_d      = more_q;
    less_d      = less_q;
    none_d      = none_q;
    run_ok_d    = run_ok_q;
    cnt_gray_d  = cnt_gray_q;
    cnt_none_d  = cnt_none_q;

    if (clr) begin
      state_d    = EMPTY;
      run_d      = '0;
      gray_d     = 1'b0;
      dist_d     = 1'b0;
      more_d     = 1'b0;
      less_d     = 1'b0;
      none_d     = 1'b0;
      run_ok_d   = 1'b0;
      cnt_gray_d = '0;
      cnt_none_d = '0;
    end else if (bus.in_valid) begin
      prev_d = bus.in_data;
      case (state_q)
        EMPTY: state_d = TRACK;
        TRACK: begin
          out_valid_d = 1'b1;
          gray_d      = gray_c;
          dist_d      = dist_c;
          more_d      = more_c;
          less_d      = less_c;
          none_d      = none_c;
          run_d       = run_next;
          run_ok_d    = (run_next == RUN_MAX);
          if (gray_c && cnt_gray_q != '1) cnt_gray_d = cnt_gray_q + CNT_W'(1);
          if (none_c && cnt_none_q != '1) cnt_none_d = cnt_none_q + CNT_W'(1);
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      prev_q      <= '0;
      run_q       <= '0;
      out_valid_q <= 1'b0;
      gray_q      <= 1'b0;
      dist_q      <= 1'b0;
      more_q      <= 1'b0;
      less_q      <= 1'b0;
      none_q      <= 1'b0;
      run_ok_q    <= 1'b0;
      cnt_gray_q  <= '0;
      cnt_none_q  <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      run_q       <= run_d;
      out_valid_q <= out_valid_d;
      gray_q      <= gray_d;
      dist_q      <= dist_d;
      more_q      <= more_d;
      less_q      <= less_d;
      none_q      <= none_d;
      run_ok_q    <= run_ok_d;
      cnt_gray_q  <= cnt_gray_d;
      cnt_none_q  <= cnt_none_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.gray        = gray_q;
  assign bus.dist_match  = dist_q;
  assign bus.more        = more_q;
  assign bus.less        = less_q;
  assign bus.no_relation = none_q;
  assign bus.run_ok      = run_ok_q;
  assign bus.cnt_gray    = cnt_gray_q;
  assign bus.cnt_none    = cnt_none_q;
  assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_code_step_monitor.sv
// Bench for code_step_monitor: directed scenarios plus a random stream, all checked
// against an integer-arithmetic reference model of the step relations.
module tb_code_step_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic s_clr = 1'b0;

  always #5 clk = ~clk;

  code_step_if #(.WIDTH(3), .CNT_W(8)) bus ();
  code_step_if #(.WIDTH(3), .CNT_W(2)) sbus ();

  code_step_monitor #(.WIDTH(3), .DIST(3), .RUN_LEN(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus)
  );

  code_step_monitor #(.WIDTH(3), .DIST(3), .RUN_LEN(4), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .clr(s_clr), .bus(sbus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_has_prev;
  int m_prev, m_run, m_cg, m_cn;
  bit m_ov, m_gray, m_dist, m_more, m_less, m_none, m_runok;

  task automatic model_reset();
    m_has_prev = 0; m_prev = 0; m_run = 0; m_cg = 0; m_cn = 0;
    m_ov = 0; m_gray = 0; m_dist = 0; m_more = 0; m_less = 0; m_none = 0; m_runok = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit c);
    int diff, adiff, x, pc;
    m_ov = 0;
    if (c) begin
      m_has_prev = 0; m_run = 0; m_cg = 0; m_cn = 0;
      m_gray = 0; m_dist = 0; m_more = 0; m_less = 0; m_none = 0; m_runok = 0;
    end else if (v) begin
      if (m_has_prev) begin
        diff  = d - m_prev;
        adiff = (diff < 0) ? -diff : diff;
        x     = d ^ m_prev;
        pc    = 0;
        for (int b = 0; b < 3; b++) pc += (x >> b) & 1;
        m_gray  = (pc == 1);
        m_dist  = (adiff == 3);
        m_more  = (diff == 1);
        m_less  = (diff == -1);
        m_none  = !(m_gray || m_dist || m_more || m_less);
        m_run   = m_gray ? ((m_run < 4) ? m_run + 1 : 4) : 0;
        m_runok = (m_run == 4);
        if (m_gray && m_cg < 255) m_cg++;
        if (m_none && m_cn < 255) m_cn++;
        m_ov = 1;
      end
      m_has_prev = 1;
      m_prev = d;
    end
  endtask

  function automatic logic [22:0] obs_vec();
    return {bus.out_valid, bus.gray, bus.dist_match, bus.more, bus.less,
            bus.no_relation, bus.run_ok, bus.cnt_gray, bus.cnt_none};
  endfunction

  function automatic logic [22:0] exp_vec();
    return {m_ov, m_gray, m_dist, m_more, m_less, m_none, m_runok, 8'(m_cg), 8'(m_cn)};
  endfunction

  // One clock: drive at negedge, sample 1 time unit after the rising edge.
  task automatic apply(input bit v, input int d, input bit c);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = 3'(d);
    clr          = c;
    @(posedge clk);
    #1;
    model_step(v, d, c);
    bus.in_valid = 1'b0;
    clr          = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (obs_vec() !== 23'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", obs_vec(), 23'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_first_pair();
    apply(1, 5, 0);
    n_checks++;
    if (obs_vec() !== exp_vec() || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_sample_no_pulse: got %h expected %h", obs_vec(), exp_vec());
    end
    apply(1, 4, 0);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL pair_5_4: got %h expected %h", obs_vec(), exp_vec());
    end
    n_checks++;
    if ({bus.out_valid, bus.gray, bus.less, bus.more, bus.dist_match, bus.no_relation} !== 6'b111000
        || bus.cnt_gray !== 8'd1) begin
      n_fail++;
      $display("FAIL pair_5_4_literal: got ov/g/l/m/d/n=%b%b%b%b%b%b cnt_gray=%0d expected 111000 cnt_gray=1",
               bus.out_valid, bus.gray, bus.less, bus.more, bus.dist_match, bus.no_relation, bus.cnt_gray);
    end
    apply(0, 0, 0);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL idle_hold: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_dist_wrap();
    int seq[4] = '{0, 3, 7, 0};
    apply(0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      apply(1, seq[i], 0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL dist_wrap_step%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (bus.no_relation !== 1'b1 || bus.more !== 1'b0 || bus.cnt_none !== 8'd1) begin
      n_fail++;
      $display("FAIL no_wrap_7_0: got none=%b more=%b cnt_none=%0d expected none=1 more=0 cnt_none=1",
               bus.no_relation, bus.more, bus.cnt_none);
    end
  endtask

  task automatic test_gray_run();
    int seq[6] = '{0, 1, 3, 2, 6, 0};
    apply(0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      apply(1, seq[i], 0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL gray_run_step%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (i == 4) begin
        n_checks++;
        if (bus.run_ok !== 1'b1) begin
          n_fail++;
          $display("FAIL run_ok_at_4th: got %b expected 1", bus.run_ok);
        end
      end
      for (int g = 0; g < 2; g++) begin
        apply(0, 0, 0);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL gray_run_gap%0d: got %h expected %h", i, obs_vec(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_clr();
    apply(1, 2, 0);
    apply(1, 3, 0);
    apply(1, 1, 1);
    n_checks++;
    if (obs_vec() !== exp_vec() || obs_vec() !== 23'h0) begin
      n_fail++;
      $display("FAIL clr_zero: got %h expected %h", obs_vec(), 23'h0);
    end
    apply(1, 5, 0);
    n_checks++;
    if (obs_vec() !== exp_vec() || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_reload: got %h expected %h", obs_vec(), exp_vec());
    end
    apply(1, 4, 0);
    n_checks++;
    if (obs_vec() !== exp_vec() || bus.less !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_first_cmp: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_async_reset();
    int seq[5] = '{0, 1, 0, 1, 0};
    apply(0, 0, 1);
    foreach (seq[i]) apply(1, seq[i], 0);
    apply(1, 7, 0);
    apply(1, 0, 0);
    apply(1, 1, 0);
    apply(1, 0, 0);
    apply(1, 1, 0);
    apply(1, 3, 0);
    n_checks++;
    if (obs_vec() !== exp_vec() || bus.run_ok !== 1'b1 || bus.cnt_none === 8'd0) begin
      n_fail++;
      $display("FAIL pre_reset_state: got %h expected %h", obs_vec(), exp_vec());
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (obs_vec() !== 23'h0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", obs_vec(), 23'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 2, 0);
    n_checks++;
    if (obs_vec() !== exp_vec() || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_no_pulse: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_cnt_saturate();
    int seq[6]   = '{0, 1, 0, 1, 0, 1};
    int exp_c[6] = '{0, 1, 2, 3, 3, 3};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sbus.in_valid = 1'b1;
      sbus.in_data  = 3'(seq[i]);
      @(posedge clk);
      #1;
      sbus.in_valid = 1'b0;
      n_checks++;
      if (sbus.cnt_gray !== 2'(exp_c[i]) || sbus.out_valid !== (i != 0)) begin
        n_fail++;
        $display("FAIL cnt_sat_step%0d: got cnt=%0d ov=%b expected cnt=%0d ov=%b",
                 i, sbus.cnt_gray, sbus.out_valid, exp_c[i], i != 0);
      end
    end
  endtask

  task automatic test_random();
    bit v, c;
    int d;
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = (m_has_prev && $urandom_range(0, 1)) ? (m_prev ^ (1 << $urandom_range(0, 2))) : $urandom_range(0, 7);
      apply(v, d, c);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    sbus.in_valid = 1'b0;
    sbus.in_data  = '0;
    model_reset();
    test_reset();
    test_first_pair();
    test_dist_wrap();
    test_gray_run();
    test_clr();
    test_cnt_saturate();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
